// File: rtl/div_pkg.sv
// div_pkg: shared constants and types for the RV32M divide sequencer.
//   - funct3 encodings of DIV/DIVU/REM/REMU
//   - sequencer state enum
//   - op codes presented to the iterative divider, plus funct3 -> op mapping
//   - architectural special results (divide-by-zero quotient, signed overflow quotient)
package div_pkg;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    localparam logic [2:0] DIV_OP_DIV  = 3'd0;
    localparam logic [2:0] DIV_OP_DIVU = 3'd1;
    localparam logic [2:0] DIV_OP_REM  = 3'd2;
    localparam logic [2:0] DIV_OP_REMU = 3'd3;

    // Special results are defined for the 32-bit datapath.
    localparam logic [31:0] RES_ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] RES_INT_MIN  = 32'h8000_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DRAIN,
        S_RESP
    } state_t;

    function automatic logic [2:0] div_op_of(input logic [2:0] funct3);
        case (funct3)
            F3_DIVU: return DIV_OP_DIVU;
            F3_REM:  return DIV_OP_REM;
            F3_REMU: return DIV_OP_REMU;
            default: return DIV_OP_DIV;
        endcase
    endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// div_sequencer_if: request/response handshake, flush and divider-side bus of
// the divide sequencer.
//   master: execute stage + divider side (drives requests, flush, divider status)
//   slave : div_sequencer (drives ready, response and divider launch)
interface div_sequencer_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_funct3;
    logic [XLEN-1:0]  req_rs1;
    logic [XLEN-1:0]  req_rs2;
    logic [TAG_W-1:0] req_tag;
    logic             flush;
    logic             resp_valid;
    logic [XLEN-1:0]  resp_result;
    logic [TAG_W-1:0] resp_tag;
    logic             div_start;
    logic [XLEN-1:0]  div_num;
    logic [XLEN-1:0]  div_den;
    logic [2:0]       div_op;
    logic             div_busy;
    logic [XLEN-1:0]  div_result;

    modport master (
        output req_valid, req_funct3, req_rs1, req_rs2, req_tag, flush,
               div_busy, div_result,
        input  req_ready, resp_valid, resp_result, resp_tag,
               div_start, div_num, div_den, div_op
    );

    modport slave (
        input  req_valid, req_funct3, req_rs1, req_rs2, req_tag, flush,
               div_busy, div_result,
        output req_ready, resp_valid, resp_result, resp_tag,
               div_start, div_num, div_den, div_op
    );
endinterface

// File: rtl/div_special_case.sv
// div_special_case: combinational detection of RV32M divide-by-zero and
// signed overflow, producing the architectural result without the divider.
//   f3_lo   : funct3[1:0] (bit0 = unsigned, bit1 = remainder)
//   rs1/rs2 : numerator / denominator
//   special : request resolved locally
//   result  : local result, valid when special=1
module div_special_case
    import div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      f3_lo,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            special,
    output logic [XLEN-1:0] result
);
    logic is_signed;
    logic is_rem;
    logic by_zero;
    logic overflow;

    always_comb begin
        is_signed = ~f3_lo[0];
        is_rem    = f3_lo[1];
        by_zero   = (rs2 == '0);
        overflow  = is_signed && (rs1 == XLEN'(RES_INT_MIN)) && (rs2 == '1);
        special   = by_zero || overflow;
        result    = '0;
        // Divide-by-zero takes priority over overflow.
        if (by_zero)
            result = is_rem ? rs1 : XLEN'(RES_ALL_ONES);
        else if (overflow)
            result = is_rem ? '0 : XLEN'(RES_INT_MIN);
    end
endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle controller between execute and a 32-cycle
// iterative divider. Resolves divide-by-zero/overflow locally, otherwise
// launches the divider, waits for busy to rise and fall, returns the result
// with its tag. Handles flush (drain the divider, discard result).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : div_sequencer_if.slave (request, response, flush, divider side)
// Optional build macro DIV_REUSE_CACHE_EN: one-entry {funct3, rs1, rs2, result}
// cache; a hit responds the cycle after accept without starting the divider.
//
// state    | meaning
// IDLE     | ready for a request
// LAUNCH   | start pulse to divider (held off while divider still busy)
// WAIT     | divider running, capture result on busy fall
// DRAIN    | flushed; let divider finish, drop result
// RESP     | one-cycle response pulse
module div_sequencer
    import div_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic           clk,
    input  logic           rst,
    div_sequencer_if.slave bus
);
    state_t           state;
    state_t           state_nx;
    logic             seen_busy;
    logic             accept;
    logic             done;
    logic             req_ready_c;
    logic             fill;
    logic [XLEN-1:0]  result_q;
    logic [TAG_W-1:0] tag_q;
    logic [XLEN-1:0]  num_q;
    logic [XLEN-1:0]  den_q;
    logic [2:0]       op_q;
    logic             sp_hit;
    logic [XLEN-1:0]  sp_result;
    logic             cache_hit;
    logic [XLEN-1:0]  cache_result;

    div_special_case #(.XLEN(XLEN)) u_special (
        .f3_lo   (bus.req_funct3[1:0]),
        .rs1     (bus.req_rs1),
        .rs2     (bus.req_rs2),
        .special (sp_hit),
        .result  (sp_result)
    );

    always_comb begin
        state_nx       = state;
        req_ready_c    = (state == S_IDLE);
        bus.div_start  = 1'b0;
        bus.resp_valid = 1'b0;
        accept         = req_ready_c && bus.req_valid && !bus.flush;
        done           = seen_busy && !bus.div_busy;
        fill           = 1'b0;
        case (state)
            S_IDLE:
                if (accept)
                    state_nx = (sp_hit || cache_hit) ? S_RESP : S_LAUNCH;
            S_LAUNCH: begin
                // A divider left busy by a reset mid-operation delays the launch.
                bus.div_start = !bus.div_busy;
                if (bus.flush)
                    state_nx = S_DRAIN;
                else if (!bus.div_busy)
                    state_nx = S_WAIT;
            end
            S_WAIT:
                if (bus.flush)
                    state_nx = S_DRAIN;
                else if (done) begin
                    fill     = 1'b1;
                    state_nx = S_RESP;
                end
            S_DRAIN:
                if (done)
                    state_nx = S_IDLE;
            S_RESP: begin
                bus.resp_valid = !bus.flush;
                state_nx       = S_IDLE;
            end
            default:
                state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            seen_busy <= 1'b0;
            result_q  <= '0;
            tag_q     <= '0;
            num_q     <= '0;
            den_q     <= '0;
            op_q      <= '0;
        end else begin
            state <= state_nx;
            if (state == S_WAIT || state == S_DRAIN)
                seen_busy <= seen_busy | bus.div_busy;
            else
                seen_busy <= 1'b0;
            if (accept) begin
                tag_q <= bus.req_tag;
                num_q <= bus.req_rs1;
                den_q <= bus.req_rs2;
                op_q  <= div_op_of(bus.req_funct3);
                if (sp_hit)
                    result_q <= sp_result;
                else if (cache_hit)
                    result_q <= cache_result;
            end
            if (fill)
                result_q <= bus.div_result;
        end
    end

`ifdef DIV_REUSE_CACHE_EN
    logic            c_valid;
    logic [2:0]      c_f3;
    logic [XLEN-1:0] c_rs1;
    logic [XLEN-1:0] c_rs2;
    logic [XLEN-1:0] c_res;
    logic [2:0]      f3_q;

    assign cache_hit    = c_valid && (bus.req_funct3 == c_f3) &&
                          (bus.req_rs1 == c_rs1) && (bus.req_rs2 == c_rs2);
    assign cache_result = c_res;

    always_ff @(posedge clk) begin
        if (rst) begin
            c_valid <= 1'b0;
            c_f3    <= '0;
            c_rs1   <= '0;
            c_rs2   <= '0;
            c_res   <= '0;
            f3_q    <= '0;
        end else begin
            if (accept)
                f3_q <= bus.req_funct3;
            if (bus.flush)
                c_valid <= 1'b0;
            else if (fill) begin
                c_valid <= 1'b1;
                c_f3    <= f3_q;
                c_rs1   <= num_q;
                c_rs2   <= den_q;
                c_res   <= bus.div_result;
            end
        end
    end
`else
    assign cache_hit    = 1'b0;
    assign cache_result = '0;
`endif

    assign bus.req_ready   = req_ready_c;
    assign bus.resp_result = result_q;
    assign bus.resp_tag    = tag_q;
    assign bus.div_num     = num_q;
    assign bus.div_den     = den_q;
    assign bus.div_op      = op_q;
endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a behavioural 32-cycle divider.
module tb_div_sequencer;
    import div_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    div_sequencer_if #(.XLEN(32), .TAG_W(5)) bus ();

    div_sequencer #(.XLEN(32), .TAG_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural divider: busy for 32 cycles after a start pulse.
    logic        dv_busy = 1'b0;
    logic [31:0] dv_res  = '0;
    int          dv_cnt  = 0;

    function automatic logic [31:0] dv_model(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [31:0] q;
        if (b == 0) return 32'h0;
        case (op)
            DIV_OP_DIV:  q = $signed(a) / $signed(b);
            DIV_OP_REM:  q = $signed(a) % $signed(b);
            DIV_OP_DIVU: q = a / b;
            default:     q = a % b;
        endcase
        return q;
    endfunction

    always @(posedge clk) begin
        if (bus.div_start && !dv_busy) begin
            dv_busy <= 1'b1;
            dv_cnt  <= 32;
            dv_res  <= dv_model(bus.div_op, bus.div_num, bus.div_den);
        end else if (dv_busy) begin
            dv_cnt <= dv_cnt - 1;
            if (dv_cnt == 1) dv_busy <= 1'b0;
        end
    end

    assign bus.div_busy   = dv_busy;
    assign bus.div_result = dv_res;

    int start_cnt  = 0;
    int wide_start = 0;
    logic prev_start = 1'b0;
    always @(negedge clk) begin
        if (bus.div_start === 1'b1) start_cnt++;
        if (bus.div_start === 1'b1 && prev_start) wide_start++;
        prev_start = (bus.div_start === 1'b1);
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

`ifdef DIV_REUSE_CACHE_EN
    localparam int HIT_LO = 1, HIT_HI = 1, HIT_STARTS = 0;
`else
    localparam int HIT_LO = 34, HIT_HI = 36, HIT_STARTS = 1;
`endif

    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp,
                          input int lat_lo, input int lat_hi, input int starts);
        int lat;
        int s0;
        bit got;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_funct3 = f3;
        bus.req_rs1    = a;
        bus.req_rs2    = b;
        bus.req_tag    = tag;
        s0 = start_cnt;
        chk({name, "_ready"}, {31'b0, bus.req_ready}, 32'd1);
        @(posedge clk);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            bus.req_valid = 1'b0;
            if (bus.resp_valid) got = 1'b1;
        end
        chk({name, "_resp_seen"}, {31'b0, got}, 32'd1);
        chk({name, "_result"}, bus.resp_result, exp);
        chk({name, "_tag"}, {27'b0, bus.resp_tag}, {27'b0, tag});
        chk({name, "_lat_in_window"}, {31'b0, (lat >= lat_lo && lat <= lat_hi)}, 32'd1);
        chk({name, "_starts"}, start_cnt - s0, starts);
        @(negedge clk);
        chk({name, "_resp_one_cycle"}, {31'b0, bus.resp_valid}, 32'd0);
    endtask

    initial begin
        int n;
        int saw_resp;
        int s0;
        bus.req_valid  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_rs1    = '0;
        bus.req_rs2    = '0;
        bus.req_tag    = '0;
        bus.flush      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("rst_ready",  {31'b0, bus.req_ready},  32'd1);
        chk("rst_resp_v", {31'b0, bus.resp_valid}, 32'd0);
        chk("rst_start",  {31'b0, bus.div_start},  32'd0);
        chk("rst_result", bus.resp_result, 32'd0);
        chk("rst_tag",    {27'b0, bus.resp_tag}, 32'd0);
        chk("rst_num",    bus.div_num, 32'd0);
        chk("rst_den",    bus.div_den, 32'd0);
        chk("rst_op",     {29'b0, bus.div_op}, 32'd0);

        run_op("div_100_7",   F3_DIV,  32'd100,       32'd7,        5'd1,  32'd14,        34, 36, 1);
        run_op("remu_ff_10",  F3_REMU, 32'hFFFF_FFFF, 32'h10,       5'd2,  32'hF,         34, 36, 1);
        run_op("div_by0",     F3_DIV,  32'd5,         32'd0,        5'd5,  32'hFFFF_FFFF, 1,  1,  0);
        run_op("rem_by0",     F3_REM,  32'd5,         32'd0,        5'd6,  32'd5,         1,  1,  0);
        run_op("div_ovf",     F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000, 1,  1,  0);
        run_op("rem_ovf",     F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'd0,         1,  1,  0);
        run_op("divu_no_ovf", F3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0,        34, 36, 1);

        // Flush while the divider is running.
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_funct3 = F3_DIV;
        bus.req_rs1    = 32'd1000;
        bus.req_rs2    = 32'd10;
        bus.req_tag    = 5'd9;
        s0 = start_cnt;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (start_cnt == s0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("flush_launched", start_cnt - s0, 32'd1);
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        saw_resp = 0;
        n = 0;
        while (!bus.req_ready && n < 100) begin
            if (bus.resp_valid) saw_resp++;
            @(negedge clk);
            n++;
        end
        chk("flush_ready_back", {31'b0, bus.req_ready}, 32'd1);
        chk("flush_ready_after_busy", {31'b0, dv_busy}, 32'd0);
        chk("flush_busy_lasted", {31'b0, (n >= 15)}, 32'd1);
        repeat (3) begin
            if (bus.resp_valid) saw_resp++;
            @(negedge clk);
        end
        chk("flush_no_resp", saw_resp, 32'd0);
        chk("flush_no_relaunch", start_cnt - s0, 32'd1);

        run_op("div_m20_3", F3_DIV, 32'hFFFF_FFEC, 32'd3, 5'd11, 32'hFFFF_FFFA, 34, 36, 1);

        // Flush in IDLE beats a simultaneous request.
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_funct3 = F3_DIV;
        bus.req_rs1    = 32'd5;
        bus.req_rs2    = 32'd0;
        bus.req_tag    = 5'd12;
        bus.flush      = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        saw_resp = 0;
        repeat (3) begin
            if (bus.resp_valid) saw_resp++;
            @(negedge clk);
        end
        chk("idle_flush_blocks", saw_resp, 32'd0);
        chk("idle_flush_tag_kept", {27'b0, bus.resp_tag}, 32'd11);

        // Repeat identical request: cache hit when enabled, full latency otherwise.
        run_op("divu_1000_10_a", F3_DIVU, 32'd1000, 32'd10, 5'd3, 32'd100, 34, 36, 1);
        run_op("divu_1000_10_b", F3_DIVU, 32'd1000, 32'd10, 5'd4, 32'd100, HIT_LO, HIT_HI, HIT_STARTS);

        chk("start_pulse_width", wide_start, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
